sdram_bist: RTL and testbench



---
 rtl/sdram_bist_if.sv | 25 ++
 rtl/sdram_bist.sv | 192 +++++++++++++++++++
 tb/tb_sdram_bist.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_bist_if.sv
// sdram_bist_if: request/strobe bundle between the BIST sequencer (master)
// and the SdramCtrl request port (slave).
interface sdram_bist_if #(
   parameter int ADDR_WIDTH = 23,
   parameter int DATA_WIDTH = 16
);
   logic                  rd;
   logic                  wr;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  opBegun;
   logic                  wrDone;
   logic                  rdDone;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output rd, wr, addr, wdata,
      input  opBegun, wrDone, rdDone, rdata
   );

   modport slave (
      input  rd, wr, addr, wdata,
      output opBegun, wrDone, rdDone, rdata
   );
endinterface

// File: rtl/sdram_bist.sv
// sdram_bist: write an address-derived pattern over a word range, read it back and count mismatches.
// Define SDRAM_BIST_INVERT_PASS_EN to add a second write/read pass using the inverted pattern.
module sdram_bist #(
   parameter int                    ADDR_WIDTH = 23,
   parameter int                    DATA_WIDTH = 16,
   parameter int                    NUM_WORDS  = 1024,
   parameter logic [DATA_WIDTH-1:0] SEED       = 16'hA5C3,
   parameter int                    ERR_WIDTH  = 8,
   parameter int                    TIMEOUT    = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic                  timeout_o,
   output logic [ERR_WIDTH-1:0]  errCount_o,
   output logic [ADDR_WIDTH-1:0] failAddr_o,
   sdram_bist_if.master          ctrl_if
);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, FINISH
`ifdef SDRAM_BIST_INVERT_PASS_EN
      , PASS2
`endif
   } state_t;

   state_t                r_state, w_state_next;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
   logic [TMO_W-1:0]      r_tmo, w_tmo_next;
   logic [ERR_WIDTH-1:0]  r_err, w_err_next;
   logic [ADDR_WIDTH-1:0] r_fail, w_fail_next;
   logic                  r_timeout, w_timeout_next;
   logic                  r_pass, w_pass_next;
   logic                  r_rd, r_wr, r_busy, r_done;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  w_inv, w_inv_next;
   logic                  w_last, w_tmo_hit;
   logic [DATA_WIDTH-1:0] w_expected;
   logic                  w_unused;

   function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a, input logic inv);
      logic [DATA_WIDTH-1:0] p;
      p = DATA_WIDTH'(a) ^ SEED;
      return inv ? ~p : p;
   endfunction

`ifdef SDRAM_BIST_INVERT_PASS_EN
   logic r_inv;
   assign w_inv = r_inv;

   always_ff @(posedge clk_i) begin
      if (rst_i) r_inv <= 1'b0;
      else       r_inv <= w_inv_next;
   end
`else
   assign w_inv      = 1'b0;
   assign w_inv_next = 1'b0;
`endif

   // opBegun is informational only; sequencing relies solely on the done strobes.
   assign w_unused   = ctrl_if.opBegun;
   assign w_last     = (r_addr == LAST_ADDR);
   assign w_tmo_hit  = (r_tmo == TMO_W'(TIMEOUT - 1));
   assign w_expected = pat(r_addr, w_inv);

   always_comb begin
      w_state_next   = r_state;
      w_addr_next    = r_addr;
      w_tmo_next     = '0;
      w_err_next     = r_err;
      w_fail_next    = r_fail;
      w_timeout_next = r_timeout;
      w_pass_next    = r_pass;
`ifdef SDRAM_BIST_INVERT_PASS_EN
      w_inv_next     = r_inv;
`endif
      unique case (r_state)
         IDLE: begin
            if (start_i) begin
               w_state_next   = WR_REQ;
               w_addr_next    = '0;
               w_err_next     = '0;
               w_fail_next    = '0;
               w_timeout_next = 1'b0;
               w_pass_next    = 1'b0;
`ifdef SDRAM_BIST_INVERT_PASS_EN
               w_inv_next     = 1'b0;
`endif
            end
         end
         WR_REQ: begin
            if (ctrl_if.wrDone) begin
               w_state_next = WR_GAP;
            end else if (w_tmo_hit) begin
               w_state_next   = FINISH;
               w_timeout_next = 1'b1;
            end else begin
               w_tmo_next = r_tmo + 1'b1;
            end
         end
         WR_GAP: begin
            w_state_next = w_last ? RD_REQ : WR_REQ;
            w_addr_next  = w_last ? '0 : r_addr + 1'b1;
         end
         RD_REQ: begin
            if (ctrl_if.rdDone) begin
               w_state_next = RD_GAP;
               if (ctrl_if.rdata != w_expected) begin
                  if (r_err != '1) w_err_next  = r_err + 1'b1;
                  // The counter never returns to zero, so zero means no earlier mismatch.
                  if (r_err == '0) w_fail_next = r_addr;
               end
            end else if (w_tmo_hit) begin
               w_state_next   = FINISH;
               w_timeout_next = 1'b1;
            end else begin
               w_tmo_next = r_tmo + 1'b1;
            end
         end
         RD_GAP: begin
            if (w_last) begin
`ifdef SDRAM_BIST_INVERT_PASS_EN
               w_state_next = r_inv ? FINISH : PASS2;
`else
               w_state_next = FINISH;
`endif
            end else begin
               w_state_next = RD_REQ;
               w_addr_next  = r_addr + 1'b1;
            end
         end
`ifdef SDRAM_BIST_INVERT_PASS_EN
         PASS2: begin
            w_state_next = WR_REQ;
            w_addr_next  = '0;
            w_inv_next   = 1'b1;
         end
`endif
         FINISH:  w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
      if (w_state_next == FINISH && r_state != FINISH)
         w_pass_next = (w_err_next == '0) && !w_timeout_next;
   end

   // Bus outputs are decoded from the next state so they are registered yet aligned with it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_addr    <= '0;
         r_tmo     <= '0;
         r_err     <= '0;
         r_fail    <= '0;
         r_timeout <= 1'b0;
         r_pass    <= 1'b0;
         r_rd      <= 1'b0;
         r_wr      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_data    <= '0;
      end else begin
         r_state   <= w_state_next;
         r_addr    <= w_addr_next;
         r_tmo     <= w_tmo_next;
         r_err     <= w_err_next;
         r_fail    <= w_fail_next;
         r_timeout <= w_timeout_next;
         r_pass    <= w_pass_next;
         r_rd      <= (w_state_next == RD_REQ);
         r_wr      <= (w_state_next == WR_REQ);
         r_busy    <= (w_state_next != IDLE) && (w_state_next != FINISH);
         r_done    <= (w_state_next == FINISH);
         r_data    <= pat(w_addr_next, w_inv_next);
      end
   end

   assign busy_o        = r_busy;
   assign done_o        = r_done;
   assign pass_o        = r_pass;
   assign timeout_o     = r_timeout;
   assign errCount_o    = r_err;
   assign failAddr_o    = r_fail;
   assign ctrl_if.rd    = r_rd;
   assign ctrl_if.wr    = r_wr;
   assign ctrl_if.addr  = r_addr;
   assign ctrl_if.wdata = r_data;
endmodule

// File: tb/tb_sdram_bist.sv
// tb_sdram_bist: sdram_bist against a behavioural SdramCtrl (5-cycle strobe latency) with
// randomized read corruption, spurious strobes and restart attempts, checked against a request-list model.
module tb_sdram_bist;
   localparam int AW = 23, DW = 16, NW = 16, EW = 2, TMO = 255, LAT = 5, LIMIT = 5000;
   localparam logic [DW-1:0] SEED = 16'hA5C3;
`ifdef SDRAM_BIST_INVERT_PASS_EN
   localparam int PASSES = 2;
`else
   localparam int PASSES = 1;
`endif

   typedef struct packed {
      logic          is_wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } req_t;

   logic          clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0;
   logic          busy_o, done_o, pass_o, timeout_o;
   logic [EW-1:0] errCount_o;
   logic [AW-1:0] failAddr_o;

   sdram_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   sdram_bist #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .SEED(SEED), .ERR_WIDTH(EW), .TIMEOUT(TMO)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
      .pass_o(pass_o), .timeout_o(timeout_o), .errCount_o(errCount_o), .failAddr_o(failAddr_o),
      .ctrl_if(bus.master)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0, n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [DW-1:0] pat(input int a, input int inv);
      logic [DW-1:0] p;
      p = DW'(a) ^ SEED;
      return (inv != 0) ? ~p : p;
   endfunction

   // ---------------- behavioural SdramCtrl ----------------
   logic          m_wr_done = 1'b0, m_rd_done = 1'b0, m_op_begun = 1'b0;
   logic [DW-1:0] m_rdata = '0;
   logic [DW-1:0] mem     [NW];
   logic [DW-1:0] corrupt [NW];
   bit            hang_en = 0, spurious_en = 0;
   int            hang_addr = 0, lat_cnt = 0;

   assign bus.wrDone  = m_wr_done;
   assign bus.rdDone  = m_rd_done;
   assign bus.opBegun = m_op_begun;
   assign bus.rdata   = m_rdata;

   always @(posedge clk_i) begin
      #1;
      m_wr_done  = 1'b0;
      m_rd_done  = 1'b0;
      m_op_begun = 1'b0;
      m_rdata    = DW'($urandom);
      if (bus.wr || bus.rd) begin
         lat_cnt++;
         m_op_begun = (lat_cnt == 1);
         if (lat_cnt == LAT) begin
            lat_cnt = 0;
            if (bus.wr) begin
               mem[bus.addr[3:0]] = bus.wdata;
               m_wr_done = 1'b1;
            end else if (!(hang_en && bus.addr == AW'(hang_addr))) begin
               m_rdata   = mem[bus.addr[3:0]] ^ corrupt[bus.addr[3:0]];
               m_rd_done = 1'b1;
            end
         end
      end else begin
         lat_cnt = 0;
         if (spurious_en && $urandom_range(0, 3) == 0) begin
            m_wr_done = 1'($urandom_range(0, 1));
            m_rd_done = !m_wr_done;
         end
      end
   end

   // ---------------- request monitor ----------------
   req_t          log_q[$];
   int            run_len = 0, last_len = 0, overlap_cnt = 0, unstable_cnt = 0, done_cnt = 0;
   bit            prev_wr = 0, prev_rd = 0;
   logic [AW-1:0] cur_addr = '0;
   logic [DW-1:0] cur_data = '0;

   always @(posedge clk_i) begin
      #1;
      if (done_o) done_cnt++;
      if (bus.wr && bus.rd) overlap_cnt++;
      if ((bus.wr && !prev_wr) || (bus.rd && !prev_rd)) begin
         cur_addr = bus.addr;
         cur_data = bus.wr ? bus.wdata : '0;
         log_q.push_back('{bus.wr, bus.addr, cur_data});
         run_len = 0;
      end else if ((bus.wr || bus.rd) &&
                   (bus.addr != cur_addr || (bus.wr && bus.wdata != cur_data))) begin
         unstable_cnt++;
      end
      if (bus.wr || bus.rd) run_len++;
      else if (prev_wr || prev_rd) last_len = run_len;
      prev_wr = bus.wr;
      prev_rd = bus.rd;
   end

   task automatic clear_faults();
      for (int a = 0; a < NW; a++) corrupt[a] = '0;
      hang_en     = 0;
      spurious_en = 0;
   endtask

   // One full test run, compared against the request list and results derived from the rules.
   task automatic run_test(input string name);
      req_t exp_q[$];
      int   cyc, n_err, first, exp_err, exp_fail, n;
      bit   stop;
      n_err = 0; first = -1; stop = 0;
      log_q.delete();
      overlap_cnt = 0; unstable_cnt = 0;
      @(negedge clk_i);
      done_cnt = 0;
      start_i  = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      check({name, ".busy_after_start"}, busy_o, 1'b1);
      check({name, ".wr_after_start"}, bus.wr, 1'b1);
      repeat ($urandom_range(3, 40)) @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      cyc = 0;
      while (done_o !== 1'b1 && cyc < LIMIT) begin
         @(posedge clk_i); #1;
         cyc++;
      end
      check({name, ".done_seen"}, cyc < LIMIT, 1'b1);
      check({name, ".busy_at_done"}, busy_o, 1'b0);
      @(posedge clk_i); #1;
      check({name, ".done_one_cycle"}, done_o, 1'b0);
      repeat (3) @(posedge clk_i);
      #2;
      check({name, ".done_pulses"}, done_cnt, 1);

      for (int p = 0; p < PASSES && !stop; p++) begin
         for (int a = 0; a < NW; a++) exp_q.push_back('{1'b1, AW'(a), pat(a, p)});
         for (int a = 0; a < NW && !stop; a++) begin
            exp_q.push_back('{1'b0, AW'(a), DW'(0)});
            if (hang_en && a == hang_addr) stop = 1;
            else if (corrupt[a] != '0) begin
               n_err++;
               if (first < 0) first = a;
            end
         end
      end
      exp_err  = (n_err > 3) ? 3 : n_err;
      exp_fail = (first < 0) ? 0 : first;

      check({name, ".req_count"}, log_q.size(), exp_q.size());
      n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check($sformatf("%s.req%0d", name, i), log_q[i], exp_q[i]);
      check({name, ".no_overlap"}, overlap_cnt, 0);
      check({name, ".req_stable"}, unstable_cnt, 0);
      check({name, ".last_req_len"}, last_len, stop ? TMO : LAT);
      check({name, ".errCount"}, errCount_o, exp_err);
      check({name, ".failAddr"}, failAddr_o, exp_fail);
      check({name, ".timeout"}, timeout_o, stop);
      check({name, ".pass"}, pass_o, (exp_err == 0) && !stop);
      $display("run %s: requests=%0d errCount=%0d failAddr=%0d pass=%0d timeout=%0d",
               name, log_q.size(), errCount_o, failAddr_o, pass_o, timeout_o);
   endtask

   task automatic reset_mid(input string name, input bit in_read, input int at,
                            input int exp_err, input int exp_fail);
      int cyc;
      cyc = 0;
      @(negedge clk_i) start_i = 1'b1;
      @(negedge clk_i) start_i = 1'b0;
      while (!((in_read ? bus.rd : bus.wr) && bus.addr == AW'(at)) && cyc < LIMIT) begin
         @(negedge clk_i);
         cyc++;
      end
      check({name, ".reached"}, cyc < LIMIT, 1'b1);
      check({name, ".err_before"}, errCount_o, exp_err);
      check({name, ".fail_before"}, failAddr_o, exp_fail);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      check({name, ".req_dropped"}, {bus.wr, bus.rd}, 2'b00);
      check({name, ".flags_cleared"}, {busy_o, done_o, pass_o, timeout_o}, 4'b0);
      check({name, ".err_cleared"}, errCount_o, 0);
      check({name, ".fail_cleared"}, failAddr_o, 0);
      check({name, ".addr_cleared"}, bus.addr, 0);
      @(negedge clk_i) rst_i = 1'b0;
      $display("run %s: reset applied at %s address %0d", name, in_read ? "read" : "write", at);
   endtask

   initial begin
      logic [DW-1:0] w3[$];
      clear_faults();
      repeat (3) @(posedge clk_i);
      #1;
      check("rst.flags", {busy_o, done_o, pass_o, timeout_o, bus.rd, bus.wr}, 6'b0);
      check("rst.errCount", errCount_o, 0);
      check("rst.failAddr", failAddr_o, 0);
      check("rst.addr", bus.addr, 0);
      check("rst.data", bus.wdata, 0);
      @(negedge clk_i) rst_i = 1'b0;

      run_test("clean");
      check("clean.total_requests", log_q.size(), 32 * PASSES);
      foreach (log_q[i]) if (log_q[i].is_wr && log_q[i].addr == AW'(3)) w3.push_back(log_q[i].data);
      check("clean.addr3_writes", w3.size(), PASSES);
      if (w3.size() > 0) check("clean.addr3_data", w3[0], 16'hA5C0);
`ifdef SDRAM_BIST_INVERT_PASS_EN
      if (w3.size() > 1) check("clean.addr3_pass2_data", w3[1], 16'h5A3F);
`endif

      clear_faults();
      corrupt[7]  = 16'h0001;
      corrupt[12] = DW'($urandom_range(1, 65535));
      run_test("corrupt_7_12");

      clear_faults();
      for (int a = 0; a < NW; a++) corrupt[a] = DW'($urandom_range(1, 65535));
      run_test("saturate");

      clear_faults();
      reset_mid("reset_wr9", 1'b0, 9, 0, 0);
      run_test("after_reset_wr");

      clear_faults();
      corrupt[7] = 16'h0100;
      reset_mid("reset_rd13", 1'b1, 13, 1, 7);
      clear_faults();
      run_test("after_reset_rd");

      clear_faults();
      corrupt[2] = 16'h8000;
      hang_en    = 1;
      hang_addr  = 5;
      run_test("timeout_rd5");

      for (int it = 0; it < 6; it++) begin
         clear_faults();
         spurious_en = 1;
         for (int a = 0; a < NW; a++)
            corrupt[a] = ($urandom_range(0, 5) == 0) ? DW'($urandom_range(1, 65535)) : DW'(0);
         run_test($sformatf("random%0d", it));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog expired");
   end
endmodule
